// File: rtl/asip_pkg.sv
// asip_pkg: shared definitions for the ASIP vector core pipeline control.
//   - opcode constants seen in the EX stage
//   - hz_state_t : hazard_controller sequencing state
//   - fwd_sel_t  : EX operand source select
package asip_pkg;

  localparam logic [3:0] OP_SUM   = 4'b0000;
  localparam logic [3:0] OP_SUMI  = 4'b0010;
  localparam logic [3:0] OP_MULFV = 4'b0011;
  localparam logic [3:0] OP_CMP   = 4'b0110;
  localparam logic [3:0] OP_NOP   = 4'b0111;
  localparam logic [3:0] OP_JEQ   = 4'b1001;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXM = 2'b01,
    FWD_MWB = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational operand-forwarding select for both EX operands.
// Ports:
//   ex_rs1, ex_rs2     in  sources of the instruction in EX (MSB = file select)
//   mem_rd, mem_reg_w  in  destination / write flag of the instruction in MEM
//   wb_rd,  wb_reg_w   in  destination / write flag of the instruction in WB
//   fwd_a,  fwd_b      out operand source select (RF, EX/MEM, MEM/WB)
module fwd_unit
  import asip_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW:0] ex_rs1,
  input  logic [REG_AW:0] ex_rs2,
  input  logic [REG_AW:0] mem_rd,
  input  logic            mem_reg_w,
  input  logic [REG_AW:0] wb_rd,
  input  logic            wb_reg_w,
  output fwd_sel_t        fwd_a,
  output fwd_sel_t        fwd_b
);

  // Scalar r0 is hardwired; vector v0 (MSB set) is a real register.
  localparam logic [REG_AW:0] R0 = '0;

  // The full compare includes the file-select MSB, so scalar and vector
  // registers with the same index never alias. The younger EX/MEM result wins.
  function automatic fwd_sel_t sel_src(input logic [REG_AW:0] rs);
    if (mem_reg_w && (mem_rd == rs) && (mem_rd != R0))
      return FWD_EXM;
    else if (wb_reg_w && (wb_rd == rs) && (wb_rd != R0))
      return FWD_MWB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = sel_src(ex_rs1);
    fwd_b = sel_src(ex_rs2);
  end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencer for the ASIP vector core.
// Produces stage enables, bubble flushes and PC enable for taken JEQ,
// load-use and multi-cycle MULFV, plus EX forwarding selects and a
// saturating count of stalled (pc_en=0) cycles.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal issue; branch / MULFV / load-use checked each cycle
// MUL_WAIT | MULFV holding EX; r_cnt = remaining hold cycles
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   id_rs1, id_rs2               sources of the ID instruction
//   ex_opcode, ex_rs1/2, ex_rd   EX instruction fields
//   ex_reg_w, ex_r_mem, zero     EX write/load flags, JEQ compare flag
//   mem_rd/mem_reg_w, wb_rd/wb_reg_w  writeback info for MEM and WB
//   pc_en, if_id_en, id_ex_en    PC / pipeline register enables
//   if_id_flush, id_ex_flush, ex_mem_flush  bubble inserts
//   fwd_a, fwd_b                 EX operand source selects
//   mul_busy                     MULFV holding EX
//   perf_stalls                  saturating stall-cycle counter
module hazard_controller
  import asip_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int MUL_LAT = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW:0]   id_rs1,
  input  logic [REG_AW:0]   id_rs2,
  input  logic [3:0]        ex_opcode,
  input  logic [REG_AW:0]   ex_rs1,
  input  logic [REG_AW:0]   ex_rs2,
  input  logic [REG_AW:0]   ex_rd,
  input  logic              ex_reg_w,
  input  logic              ex_r_mem,
  input  logic              zero,
  input  logic [REG_AW:0]   mem_rd,
  input  logic              mem_reg_w,
  input  logic [REG_AW:0]   wb_rd,
  input  logic              wb_reg_w,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mul_busy,
  output logic [PERF_W-1:0] perf_stalls
);

  localparam int              CNT_W    = $clog2(MUL_LAT);
  // The detect cycle is the first hold, and the release cycle is the last
  // EX cycle, so MUL_WAIT needs MUL_LAT-2 further holds.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [REG_AW:0]  R0       = '0;

  hz_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PERF_W-1:0] r_perf;
  fwd_sel_t          w_fwd_a, w_fwd_b;
  logic              w_br_taken, w_is_mul, w_load_use;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .mem_rd    (mem_rd),
    .mem_reg_w (mem_reg_w),
    .wb_rd     (wb_rd),
    .wb_reg_w  (wb_reg_w),
    .fwd_a     (w_fwd_a),
    .fwd_b     (w_fwd_b)
  );

  assign w_br_taken = (ex_opcode == OP_JEQ) && zero;
  assign w_is_mul   = (ex_opcode == OP_MULFV);
  assign w_load_use = ex_r_mem && ex_reg_w && (ex_rd != R0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Forwarding is independent of the hold, only reset overrides it.
  assign fwd_a       = rst ? FWD_RF : w_fwd_a;
  assign fwd_b       = rst ? FWD_RF : w_fwd_b;
  assign perf_stalls = r_perf;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mul_busy     = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (w_is_mul) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            mul_busy     = 1'b1;
            w_cnt_nxt    = CNT_LOAD;
            w_state_nxt  = MUL_WAIT;
          end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MUL_WAIT: begin
          if (r_cnt != '0) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            mul_busy     = 1'b1;
            w_cnt_nxt    = r_cnt - 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_perf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!pc_en && (r_perf != '1))
        r_perf <= r_perf + 1'b1;
    end
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the ASIP vector core (IF/ID/EX/MEM/WB); sits beside control_unit.
- Generates per-stage enables, flushes and PC enable for three hazards: taken JEQ, load-use and multi-cycle MULFV.
- Also generates operand-forwarding selects for EX and a saturating stall-cycle counter.
- control_unit keeps ownership of mux_pc and the datapath controls.

Parameters:
- REG_AW, 4, register index width; every register port carries REG_AW+1 bits, MSB = file select (0 scalar, 1 vector).
- MUL_LAT, 4, total cycles MULFV occupies EX; legal range ≥2.
- PERF_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  REG_AW+1  sources of the instruction in ID
- ex_opcode  in  4  opcode in EX
- ex_rs1, ex_rs2  in  REG_AW+1  sources of the instruction in EX
- ex_rd  in  REG_AW+1  destination in EX
- ex_reg_w  in  1  EX instruction writes a register
- ex_r_mem  in  1  EX instruction is a load
- zero  in  1  compare flag used by JEQ
- mem_rd  in  REG_AW+1; mem_reg_w  in  1  writeback info for the instruction in MEM
- wb_rd  in  REG_AW+1; wb_reg_w  in  1  writeback info for the instruction in WB
- pc_en  out  1  PC update enable
- if_id_en, id_ex_en  out  1  pipeline register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  insert bubble
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- mul_busy  out  1  MULFV holding EX
- perf_stalls  out  PERF_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset (async, while rst=1):
  - pc_en=0, if_id_en=0, id_ex_en=0; all three flushes=1; fwd=00; mul_busy=0.
  - state=RUN, cnt=0, perf_stalls=0.
  - Reset asserted mid-MULFV aborts the sequence immediately.
- State register: RUN, MUL_WAIT; cnt is $clog2(MUL_LAT) bits. All other outputs are Mealy/combinational from state and inputs.
- Default in RUN with no hazard: pc_en=if_id_en=id_ex_en=1, all flushes=0.
- Priority: branch > MULFV > load-use.
- Branch:
  - Taken when state=RUN and ex_opcode=JEQ and zero=1.
  - Same cycle: pc_en=1, if_id_flush=1, id_ex_flush=1.
  - Penalty is 2 cycles. Not-taken JEQ: no action.
- MULFV:
  - Detect: RUN and ex_opcode=MULFV. Assert hold (pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1, mul_busy=1), load cnt=MUL_LAT-2, go to MUL_WAIT.
  - MUL_WAIT, cnt≠0: hold, cnt−1.
  - MUL_WAIT, cnt=0: release (defaults), go to RUN.
  - EX occupancy is exactly MUL_LAT cycles.
  - Back-to-back MULFV re-triggers on the first RUN cycle.
  - MUL_LAT=2 enters MUL_WAIT with cnt=0.
- Load-use:
  - Condition: RUN and ex_r_mem and ex_reg_w and ex_rd ∈ {id_rs1, id_rs2} and ex_rd is not scalar r0.
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle.
  - Suppressed when the branch or MULFV response is active.
- Forwarding, evaluated for the EX operand against its ex_rs:
  - 01 if mem_reg_w and mem_rd=ex_rs and not scalar r0.
  - Else 10 if the same condition holds for wb.
  - Else 00.
  - EX/MEM wins over MEM/WB. Scalar and vector files never match each other (MSB is part of the compare).
  - Forwarding stays active during hold.
- perf_stalls increments on every non-reset cycle with pc_en=0, saturates at all-ones, and never wraps.

Decomposition:
- asip_pkg holds:
  - opcode constants OP_SUM=0000, OP_SUMI=0010, OP_MULFV=0011, OP_CMP=0110, OP_NOP=0111, OP_JEQ=1001;
  - hz_state_t {RUN, MUL_WAIT};
  - fwd_sel_t {FWD_RF=00, FWD_EXM=01, FWD_MWB=10}.
- Sub-module fwd_unit: purely combinational, instantiated once and producing both fwd_a and fwd_b.

Test Plan:
- Reset:
  - Assert rst mid-cycle → outputs take reset values without waiting for clk; flushes=1, perf_stalls=0.
  - Deassert → RUN; a NOP stream gives pc_en=1 and no flushes.
- Branch:
  - ex_opcode=1001, zero=1 → one cycle with pc_en=1, if_id_flush=1, id_ex_flush=1.
  - Same with zero=0 → no flush.
- MULFV, MUL_LAT=4:
  - ex_opcode=0011 held → mul_busy=1 and pc_en=0 for 3 cycles, released on the 4th; perf_stalls +3.
  - Back-to-back MULFV → 6 hold cycles total.
- Load-use:
  - ex_r_mem=1, ex_reg_w=1, ex_rd=5'h03, id_rs2=5'h03 → 1 stall cycle with id_ex_flush=1.
  - ex_rd=5'h13 (vector v3) → no stall.
  - ex_rd=5'h00 → no stall.
- Forwarding:
  - mem_rd=wb_rd=ex_rs1=5'h02, both write → fwd_a=01.
  - Clear mem_reg_w → fwd_a=10.
  - ex_rs2=5'h12 with only scalar writes → fwd_b=00.
- Saturation and priority:
  - PERF_W=2 with 5 stalls → perf_stalls=3.
  - Branch and load-use conditions in the same cycle → branch response only.
